// File: rtl/mtr_drv_pkg.sv
// Shared types and helpers for the motor drive stage.
// Speed-to-duty mapping and PWM width constants.
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] DUTY_MID = 11'd1024;

    typedef logic [PWM_W-1:0] duty_t;

    // Signed speed to offset-binary duty: flip the sign bit.
    function automatic duty_t spd2duty(input logic [PWM_W-1:0] spd);
        return {~spd[PWM_W-1], spd[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/motor_drive_pwm_chan.sv
// One wheel channel: slew-limited duty register and
// dead-time complementary PWM generator.
module pwm_chan
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME  = 6,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  duty_t       cnt_i,
    input  logic [10:0] spd_i,
    output logic        pwm1_o,
    output logic        pwm2_o,
    output logic        match_o
);

    localparam logic signed [11:0] STEP = 12'(SLEW_STEP);
    localparam logic [11:0] DT = 12'(DEADTIME);

    duty_t              tgt;
    duty_t              duty_q;
    duty_t              duty_d;
    logic signed [11:0] diff;
    logic [11:0]        hi_edge;
    logic               pwm1_d;
    logic               pwm1_q;
    logic               pwm2_d;
    logic               pwm2_q;

    // Next duty: step toward target only at the period boundary.
    always_comb begin
        tgt    = spd2duty(spd_i);
        diff   = $signed({1'b0, tgt}) - $signed({1'b0, duty_q});
        duty_d = duty_q;
        if (cnt_i == '1) begin
            if (diff > STEP) begin
                duty_d = duty_q + STEP[10:0];
            end else if (diff < -STEP) begin
                duty_d = duty_q - STEP[10:0];
            end else begin
                duty_d = tgt;
            end
        end
    end

    // Dead-time windows; 12-bit upper edge avoids wrap near full duty.
    always_comb begin
        hi_edge = {1'b0, duty_q} + DT;
        pwm1_d  = ({1'b0, cnt_i} >= DT) && (cnt_i < duty_q);
        pwm2_d  = ({1'b0, cnt_i} >= hi_edge);
        match_o = (duty_q == tgt);
    end

    // Duty and registered pin state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_MID;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm1_q <= pwm1_d;
            pwm2_q <= pwm2_d;
        end
    end

    assign pwm1_o = pwm1_q;
    assign pwm2_o = pwm2_q;

endmodule

// File: rtl/motor_drive.sv
// Motor drive top: shared period counter, two PWM
// channels and the registered settled flag.
module motor_drive
    import mtr_drv_pkg::*;
#(
    parameter int DEADTIME  = 6,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lft_pwm1,
    output logic        lft_pwm2,
    output logic        rght_pwm1,
    output logic        rght_pwm2,
    output logic        settled
);

    duty_t cnt_q;
    duty_t cnt_d;
    logic  settled_q;
    logic  settled_d;
    logic  lft_match;
    logic  rght_match;

    // Free-running period counter and settle detect.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        settled_d = lft_match && rght_match;
    end

    // Counter and settled registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
        end
    end

    pwm_chan #(
        .DEADTIME  (DEADTIME),
        .SLEW_STEP (SLEW_STEP)
    ) u_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_i   (cnt_q),
        .spd_i   (lft_spd),
        .pwm1_o  (lft_pwm1),
        .pwm2_o  (lft_pwm2),
        .match_o (lft_match)
    );

    pwm_chan #(
        .DEADTIME  (DEADTIME),
        .SLEW_STEP (SLEW_STEP)
    ) u_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_i   (cnt_q),
        .spd_i   (rght_spd),
        .pwm1_o  (rght_pwm1),
        .pwm2_o  (rght_pwm2),
        .match_o (rght_match)
    );

    assign settled = settled_q;

endmodule
